// File: rtl/ps2_cmd_pkg.sv
// Shared byte constants, FSM state encoding and state-mapping helpers
// for the PS/2 keyboard command sequencer.
package ps2_cmd_pkg;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LED  = 8'hED;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

    typedef enum logic [2:0] {
        ST_INIT_SEND,
        ST_INIT_WAIT_ACK,
        ST_INIT_WAIT_BAT,
        ST_IDLE,
        ST_CMD_SEND,
        ST_CMD_WAIT,
        ST_ARG_SEND,
        ST_ARG_WAIT
    } state_t;

    function automatic logic is_send(state_t s);
        return (s == ST_INIT_SEND) || (s == ST_CMD_SEND) ||
               (s == ST_ARG_SEND);
    endfunction

    function automatic logic is_ack_wait(state_t s);
        return (s == ST_INIT_WAIT_ACK) || (s == ST_CMD_WAIT) ||
               (s == ST_ARG_WAIT);
    endfunction

    function automatic state_t wait_of(state_t s);
        state_t r;
        r = ST_IDLE;
        case (s)
            ST_INIT_SEND: r = ST_INIT_WAIT_ACK;
            ST_CMD_SEND:  r = ST_CMD_WAIT;
            ST_ARG_SEND:  r = ST_ARG_WAIT;
            default:      r = ST_IDLE;
        endcase
        return r;
    endfunction

    function automatic state_t send_of(state_t s);
        state_t r;
        r = ST_IDLE;
        case (s)
            ST_INIT_WAIT_ACK: r = ST_INIT_SEND;
            ST_CMD_WAIT:      r = ST_CMD_SEND;
            ST_ARG_WAIT:      r = ST_ARG_SEND;
            default:          r = ST_IDLE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_timeout_counter.sv
// Loadable down-counter; expired is high in the last cycle of the
// loaded interval, so a load of N expires exactly N cycles later.
module ps2_timeout_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == WIDTH'(1));

endmodule

// File: rtl/ps2_keyboard_command_sequencer.sv
// Host-side PS/2 command sequencer: keyboard reset/BAT, LED updates with
// ACK/RESEND retries and timeouts, and forwarding of scan-code bytes.
module ps2_keyboard_command_sequencer
    import ps2_cmd_pkg::*;
#(
    parameter int ACK_TIMEOUT   = 2_500_000,
    parameter int BAT_TIMEOUT   = 50_000_000,
    parameter int MAX_RETRIES   = 3,
    parameter int INIT_ON_RESET = 1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       led_req,
    input  logic [2:0] led_mask,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       cmd_sent,
    input  logic       cmd_timed_out,
    output logic [7:0] cmd_data,
    output logic       cmd_send,
    output logic [7:0] key_data,
    output logic       key_valid,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       kb_present
);

    localparam int TMAX = (ACK_TIMEOUT > BAT_TIMEOUT) ? ACK_TIMEOUT
                                                      : BAT_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    state_t     state_q, state_d;
    logic [2:0] retry_q, retry_d;
    logic       pend_q, pend_d;
    logic [2:0] mask_q, mask_d;
    logic [2:0] cur_q, cur_d;
    logic       err_q, err_d;
    logic       kb_q, kb_d;
    logic       nak_q, nak_d;
    logic       done_d;
    logic       busy_d;
    logic       tmr_load;
    logic [TW-1:0] tmr_val;
    logic       tmr_exp;
    logic       tx_done;
    logic       rx_ack, rx_rsnd, rx_bok, rx_bfail;
    logic       do_retry;
    logic       consume;
    logic [7:0] tx_byte;

    ps2_timeout_counter #(.WIDTH(TW)) u_timer (
        .clk        (CLOCK_50),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_val),
        .expired    (tmr_exp)
    );

    assign tx_done  = cmd_send & (cmd_sent | cmd_timed_out);
    assign rx_ack   = rx_valid & (rx_data == RSP_ACK);
    assign rx_rsnd  = rx_valid & (rx_data == RSP_RESEND);
    assign rx_bok   = rx_valid & (rx_data == RSP_BAT_OK);
    assign rx_bfail = rx_valid & (rx_data == RSP_BAT_FAIL);
    // A failed transmit behaves like a RESEND; a reply in the expiry cycle beats the timer
    assign do_retry = nak_q | rx_rsnd | (~rx_ack & tmr_exp);

    assign consume = (is_ack_wait(state_q) & (rx_ack | rx_rsnd)) |
                     ((state_q == ST_INIT_WAIT_BAT) &
                      (rx_ack | rx_rsnd | rx_bok | rx_bfail));

    always_comb begin
        tx_byte = 8'h00;
        case (state_q)
            ST_INIT_SEND: tx_byte = CMD_RESET;
            ST_CMD_SEND:  tx_byte = CMD_SET_LED;
            ST_ARG_SEND:  tx_byte = {5'b0, cur_q};
            default:      tx_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        pend_d   = pend_q;
        mask_d   = mask_q;
        cur_d    = cur_q;
        err_d    = err_q;
        kb_d     = kb_q;
        nak_d    = nak_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = TW'(ACK_TIMEOUT);

        if (led_req) begin
            mask_d = led_mask;
            if ((state_q != ST_IDLE) || pend_q) pend_d = 1'b1;
        end

        unique case (state_q)
            ST_INIT_SEND, ST_CMD_SEND, ST_ARG_SEND: begin
                if (tx_done) begin
                    state_d  = wait_of(state_q);
                    tmr_load = 1'b1;
                    nak_d    = cmd_timed_out;
                end
            end
            ST_INIT_WAIT_ACK, ST_CMD_WAIT, ST_ARG_WAIT: begin
                nak_d = 1'b0;
                if (do_retry) begin
                    if (retry_q == 3'(MAX_RETRIES)) begin
                        err_d   = 1'b1;
                        retry_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        retry_d = retry_q + 3'd1;
                        state_d = send_of(state_q);
                    end
                end else if (rx_ack) begin
                    retry_d = '0;
                    case (state_q)
                        ST_INIT_WAIT_ACK: begin
                            state_d  = ST_INIT_WAIT_BAT;
                            tmr_load = 1'b1;
                            tmr_val  = TW'(BAT_TIMEOUT);
                        end
                        ST_CMD_WAIT: state_d = ST_ARG_SEND;
                        default: begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end
            ST_INIT_WAIT_BAT: begin
                if (rx_bok) begin
                    kb_d    = 1'b1;
                    state_d = ST_IDLE;
                end else if (rx_bfail || (tmr_exp && !rx_valid)) begin
                    kb_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (led_req || pend_q) begin
                    state_d = ST_CMD_SEND;
                    pend_d  = 1'b0;
                    err_d   = 1'b0;
                    retry_d = '0;
                    cur_d   = led_req ? led_mask : mask_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE) | pend_d;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= (INIT_ON_RESET != 0) ? ST_INIT_SEND : ST_IDLE;
            retry_q    <= '0;
            pend_q     <= 1'b0;
            mask_q     <= '0;
            cur_q      <= '0;
            err_q      <= 1'b0;
            kb_q       <= 1'b0;
            nak_q      <= 1'b0;
            cmd_send   <= 1'b0;
            cmd_data   <= 8'h00;
            key_data   <= 8'h00;
            key_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q   <= state_d;
            retry_q   <= retry_d;
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            cur_q     <= cur_d;
            err_q     <= err_d;
            kb_q      <= kb_d;
            nak_q     <= nak_d;
            busy      <= busy_d;
            done      <= done_d;
            cmd_send  <= is_send(state_q) & ~tx_done;
            if (is_send(state_q)) cmd_data <= tx_byte;
            key_valid <= rx_valid & ~consume;
            if (rx_valid && !consume) key_data <= rx_data;
        end
    end

    assign error      = err_q;
    assign kb_present = kb_q;

endmodule

// File: tb/tb_ps2_keyboard_command_sequencer.sv
// Directed bench for the PS/2 command sequencer with short timeouts
// and a retry limit of 2.
module tb_ps2_keyboard_command_sequencer;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       led_req = 1'b0;
    logic [2:0] led_mask = 3'd0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       cmd_sent = 1'b0;
    logic       cmd_timed_out = 1'b0;
    logic [7:0] cmd_data;
    logic       cmd_send;
    logic [7:0] key_data;
    logic       key_valid;
    logic       busy;
    logic       done;
    logic       error;
    logic       kb_present;

    int total = 0;
    int bad = 0;
    int ed_cnt = 0;
    int ed0 = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    ps2_keyboard_command_sequencer #(
        .ACK_TIMEOUT   (16),
        .BAT_TIMEOUT   (40),
        .MAX_RETRIES   (2),
        .INIT_ON_RESET (1)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .led_req       (led_req),
        .led_mask      (led_mask),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .cmd_sent      (cmd_sent),
        .cmd_timed_out (cmd_timed_out),
        .cmd_data      (cmd_data),
        .cmd_send      (cmd_send),
        .key_data      (key_data),
        .key_valid     (key_valid),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .kb_present    (kb_present)
    );

    always @(posedge CLOCK_50)
        if (cmd_send && cmd_sent && cmd_data == 8'hED) ed_cnt++;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_send(input logic [7:0] exp, input string tag);
        int n;
        n = 0;
        while (!cmd_send && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_req"}, 8'(cmd_send), 8'h01);
        chk(tag, cmd_data, exp);
        cmd_sent = 1'b1;
        step();
        cmd_sent = 1'b0;
    endtask

    task automatic rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic req(input logic [2:0] m);
        led_req  = 1'b1;
        led_mask = m;
        step();
        led_req  = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("rst_send", 8'(cmd_send), 8'h00);
        chk("rst_data", cmd_data, 8'h00);
        chk("rst_outs", {3'b0, busy, done, error, kb_present, key_valid},
            8'h00);
        reset = 1'b0;

        step();
        chk("init_send", 8'(cmd_send), 8'h01);
        chk("init_busy", 8'(busy), 8'h01);
        wait_send(8'hFF, "init_ff");
        rx(8'hFA);
        chk("init_ack_kv", 8'(key_valid), 8'h00);
        rx(8'hAA);
        chk("bat_kv", 8'(key_valid), 8'h00);
        chk("bat_kb", 8'(kb_present), 8'h01);
        chk("bat_busy", 8'(busy), 8'h00);
        chk("bat_err", 8'(error), 8'h00);

        rx(8'h2B);
        chk("idle_fwd_v", 8'(key_valid), 8'h01);
        chk("idle_fwd_d", key_data, 8'h2B);
        step();
        chk("idle_fwd_pulse", 8'(key_valid), 8'h00);

        req(3'b101);
        chk("led_busy", 8'(busy), 8'h01);
        chk("led_send_lag", 8'(cmd_send), 8'h00);
        step();
        chk("led_send_rise", 8'(cmd_send), 8'h01);
        wait_send(8'hED, "led_ed");
        rx(8'hFA);
        wait_send(8'h05, "led_arg");
        chk("led_done_pre", 8'(done), 8'h00);
        rx(8'hFA);
        chk("led_done", 8'(done), 8'h01);
        chk("led_err", 8'(error), 8'h00);
        chk("led_idle", 8'(busy), 8'h00);
        step();
        chk("led_done_pulse", 8'(done), 8'h00);

        ed0 = ed_cnt;
        req(3'b010);
        wait_send(8'hED, "rs_ed1");
        rx(8'hFE);
        wait_send(8'hED, "rs_ed2");
        rx(8'hFE);
        wait_send(8'hED, "rs_ed3");
        rx(8'hFA);
        chk("rs_ed_count", 8'(ed_cnt - ed0), 8'd3);
        wait_send(8'h02, "rs_arg");
        rx(8'hFA);
        chk("rs_done", 8'(done), 8'h01);

        req(3'b110);
        wait_send(8'hED, "nk_ed1");
        rx(8'hFE);
        wait_send(8'hED, "nk_ed2");
        rx(8'hFE);
        wait_send(8'hED, "nk_ed3");
        rx(8'hFE);
        chk("nk_err", 8'(error), 8'h01);
        chk("nk_busy", 8'(busy), 8'h00);
        chk("nk_done", 8'(done), 8'h00);

        req(3'b011);
        chk("to_err_clr", 8'(error), 8'h00);
        wait_send(8'hED, "to_ed");
        rx(8'hFA);
        wait_send(8'h03, "to_arg1");
        repeat (16) step();
        chk("to_retry_gap", 8'(cmd_send), 8'h00);
        chk("to_retry_err", 8'(error), 8'h00);
        step();
        chk("to_retry_rise", 8'(cmd_send), 8'h01);
        wait_send(8'h03, "to_arg2");
        repeat (16) step();
        wait_send(8'h03, "to_arg3");
        repeat (15) step();
        chk("to_err_early", 8'(error), 8'h00);
        step();
        chk("to_err_exact", 8'(error), 8'h01);
        chk("to_busy", 8'(busy), 8'h00);

        req(3'b011);
        wait_send(8'hED, "ew_ed");
        rx(8'hFA);
        wait_send(8'h03, "ew_arg");
        repeat (15) step();
        rx(8'hFA);
        chk("ew_done", 8'(done), 8'h01);
        chk("ew_err", 8'(error), 8'h00);

        req(3'b000);
        wait_send(8'hED, "fw_ed");
        rx(8'h1C);
        chk("fw_kv", 8'(key_valid), 8'h01);
        chk("fw_kd", key_data, 8'h1C);
        rx(8'hFA);
        chk("fw_ack_kv", 8'(key_valid), 8'h00);
        wait_send(8'h00, "fw_arg");
        rx(8'hFA);
        chk("fw_done", 8'(done), 8'h01);

        req(3'b001);
        step();
        req(3'b100);
        chk("pd_busy", 8'(busy), 8'h01);
        wait_send(8'hED, "pd_ed1");
        rx(8'hFA);
        wait_send(8'h01, "pd_arg1");
        rx(8'hFA);
        chk("pd_done1", 8'(done), 8'h01);
        chk("pd_busy_pend", 8'(busy), 8'h01);
        wait_send(8'hED, "pd_ed2");
        rx(8'hFA);
        begin
            int n;
            n = 0;
            while (!cmd_send && n < 20) begin
                step();
                n++;
            end
        end
        chk("pd_arg2_req", 8'(cmd_send), 8'h01);
        chk("pd_arg2", cmd_data, 8'h04);
        reset = 1'b1;
        step();
        chk("ab_send", 8'(cmd_send), 8'h00);
        chk("ab_data", cmd_data, 8'h00);
        chk("ab_outs", {3'b0, busy, done, error, kb_present, key_valid},
            8'h00);
        reset = 1'b0;

        wait_send(8'hFF, "bf_ff");
        rx(8'hFA);
        rx(8'hFC);
        chk("bf_err", 8'(error), 8'h01);
        chk("bf_kb", 8'(kb_present), 8'h00);
        chk("bf_busy", 8'(busy), 8'h00);
        chk("bf_kv", 8'(key_valid), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_command_sequencer.md
# ps2_keyboard_command_sequencer

Host-side controller that drives the command (transmit) side of the PS/2 controller and arbitrates its receive stream. After reset it resets the keyboard and waits for the keyboard's self-test result. It then serves LED-update requests as 0xED + mask byte, with ACK/RESEND handling, timeouts and bounded retries. Received bytes that are not command responses are forwarded unchanged to the scan-code consumer, which is the same path the seven-segment demo logic uses today.

## Interface
- ACK_TIMEOUT, 2_500_000, cycles allowed for a command transmit plus 0xFA/0xFE response (50 ms at 50 MHz)
- BAT_TIMEOUT, 50_000_000, cycles allowed for the self-test result after the 0xFF ACK (1 s)
- MAX_RETRIES, 3, resends allowed per byte before error; range 0..7
- INIT_ON_RESET, 1, 1 = run the keyboard reset sequence after reset; 0 = go straight to IDLE with kb_present=0
- CLOCK_50  in  1  sole clock
- reset  in  1  synchronous, active-high
- led_req  in  1  request LED update; accepted on any cycle it is high
- led_mask  in  3  bit0 scroll, bit1 num, bit2 caps; sampled in the same cycle as led_req
- rx_data  in  8  byte from PS/2 controller
- rx_valid  in  1  one-cycle strobe qualifying rx_data
- cmd_sent  in  1  strobe from controller: byte transmitted
- cmd_timed_out  in  1  strobe from controller: transmit failed
- cmd_data  out  8  byte to transmit
- cmd_send  out  1  transmit request to controller
- key_data  out  8  forwarded byte
- key_valid  out  1  one-cycle strobe for key_data
- busy  out  1  sequence in progress or pending
- done  out  1  one-cycle strobe: LED update completed with ACK
- error  out  1  sticky; cleared when the next LED sequence starts
- kb_present  out  1  high after 0xAA received

## Operation
- States: INIT_SEND, INIT_WAIT_ACK, INIT_WAIT_BAT, IDLE, CMD_SEND, CMD_WAIT, ARG_SEND, ARG_WAIT.
- Reset: all outputs 0 and cmd_data=0x00. Retry count, timer and pending flag are cleared. Next state is INIT_SEND if INIT_ON_RESET=1, else IDLE.
- *_SEND states:
  - cmd_data holds the state's byte: 0xFF in INIT, 0xED in CMD, {5'b0, mask} in ARG.
  - cmd_send stays high until cmd_sent or cmd_timed_out, then drops, and the FSM enters the matching *_WAIT.
  - cmd_timed_out is treated as a NAK.
- *_WAIT states:
  - 0xFA: advance. INIT_WAIT_ACK goes to INIT_WAIT_BAT; CMD_WAIT goes to ARG_SEND; ARG_WAIT goes to IDLE and pulses done.
  - 0xFE, a NAK, or a timer expiry: retry count +1 and re-enter the same *_SEND. If the count already equals MAX_RETRIES, set error and go to IDLE.
  - Retry count resets on every advance.
- INIT_WAIT_BAT:
  - 0xAA sets kb_present and goes to IDLE.
  - 0xFC or a BAT_TIMEOUT expiry sets error and goes to IDLE with kb_present=0. No retry.
- Forwarding:
  - In IDLE, every received byte is forwarded.
  - In WAIT states, 0xFA/0xFE (and 0xAA/0xFC in INIT_WAIT_BAT) are consumed; all other bytes are forwarded.
  - In SEND states, received bytes are forwarded.
- Requests:
  - led_req in IDLE starts CMD_SEND next cycle; the mask is latched and error is cleared.
  - led_req while busy sets pending and overwrites the latched mask, so the last mask wins.
  - On return to IDLE with pending set, CMD_SEND starts next cycle and pending is cleared. This holds even after an error.
- busy = (state != IDLE) | pending.

## Timing
- key_data/key_valid are registered: 1 cycle after rx_valid.
- cmd_send rises 1 cycle after entering *_SEND.
- The response timer loads on exit from *_SEND and counts down 1 per cycle. It expires after exactly ACK_TIMEOUT (or BAT_TIMEOUT) cycles. A response in the expiry cycle wins over the timeout.
- The timer width is $clog2 of the larger timeout; no wrap occurs.
- done is asserted in the cycle the state becomes IDLE.
- A reset asserted mid-sequence aborts immediately. cmd_send drops the next edge, and no done/error is produced.

## Structure
- Package ps2_cmd_pkg holds:
  - the byte constants: CMD_RESET 0xFF, CMD_SET_LED 0xED, RSP_ACK 0xFA, RSP_RESEND 0xFE, RSP_BAT_OK 0xAA, RSP_BAT_FAIL 0xFC;
  - the state enum.
- Sub-module ps2_timeout_counter: load, count-down and expired flag, parameterised width.

## Test plan
- Reset, then 0xFF sent, then rx 0xFA, then rx 0xAA -> kb_present=1, busy=0, error=0, no key_valid.
- led_req with mask=3'b101 -> cmd_data 0xED sent, rx 0xFA, then 0x05 sent, rx 0xFA -> done one cycle, error=0.
- During CMD_WAIT rx 0xFE twice, then 0xFA -> 0xED transmitted 3 times and the sequence completes; with MAX_RETRIES=1 -> error=1 after the second NAK.
- No response in ARG_WAIT -> error exactly ACK_TIMEOUT cycles after cmd_sent. Use ACK_TIMEOUT=16 in sim.
- rx 0x1C while in CMD_WAIT -> key_data=0x1C one cycle later; a subsequent 0xFA is consumed, not forwarded.
- led_req mask=1, then mask=4 while busy -> second sequence sends 0x04; reset asserted mid-ARG_SEND -> all outputs 0 next cycle.
